udp_decode: RTL and testbench

UDP_DECODE -- requirements
Module: udp_decode

---
 rtl/eth_pkg.sv | 15 +
 rtl/nibble_shift16.sv | 36 +++
 rtl/udp_decode.sv | 161 ++++++++++++++++
 tb/tb_udp_decode.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the UDP datagram decoder.
package eth_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HEADER  = 3'd1,
      PAYLOAD = 3'd2,
      DROP    = 3'd3,
      FLUSH   = 3'd4
   } udp_state_t;

   localparam int UDP_HDR_NIBBLES = 16;
   localparam int UDP_HDR_BYTES   = 8;

endpackage

// File: rtl/nibble_shift16.sv
// 16-bit MSB-first nibble shift register with load enable.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset, clears the register
//   load_en : shift din into the low nibble this cycle
//   din     : nibble to shift in
//   q       : registered 16-bit value (first nibble shifted ends up in [15:12])
module nibble_shift16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_en,
   input  logic [3:0]  din,
   output logic [15:0] q
);

   logic [15:0] q_d;
   logic [15:0] q_q;

   always_comb begin
      q_d = q_q;
      if (load_en) begin
         q_d = {q_q[11:0], din};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/udp_decode.sv
// UDP datagram decoder: parses the 8-byte UDP header from an IPv4 payload
// nibble stream and forwards the payload of datagrams addressed to LISTEN_PORT.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for the first nibble of a frame
// HEADER  | capturing header nibbles 1..15 (nibble 0 taken in IDLE)
// PAYLOAD | forwarding payload nibbles, down-counter tracks remainder
// DROP    | datagram for another port, swallow until valid low
// FLUSH   | datagram done or bad, swallow padding until valid low
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   valid, din         : input nibble stream, high nibble of each byte first
//   dout_ready, dout   : registered payload nibble, one cycle after din
//   src_port, dst_port : header fields of the current frame
//   frame_done         : pulse with the last payload nibble
//   err                : pulse on bad length or truncated datagram
module udp_decode #(
   parameter logic [15:0] LISTEN_PORT = 16'd8080
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [3:0]  din,
   output logic        dout_ready,
   output logic [3:0]  dout,
   output logic [15:0] src_port,
   output logic [15:0] dst_port,
   output logic        frame_done,
   output logic        err
);

   import eth_pkg::*;

   localparam logic [15:0] HDR_LEN  = 16'(UDP_HDR_BYTES);
   localparam logic [4:0]  HDR_LAST = 5'(UDP_HDR_NIBBLES - 1);

   udp_state_t  state_q, state_d;
   logic [4:0]  hdr_cnt_q, hdr_cnt_d;
   logic [16:0] rem_q, rem_d;
   logic        wait_low_q, wait_low_d;
   logic        dout_ready_q, dout_ready_d;
   logic [3:0]  dout_q, dout_d;
   logic        frame_done_q, frame_done_d;
   logic        err_q, err_d;

   logic        hdr_take;
   logic [4:0]  hdr_idx;
   logic        ld_src, ld_dst, ld_len;
   logic [15:0] udp_len;

   // After a reset the stream may be mid-frame; wait_low_q blocks a new
   // header from starting until valid has been seen low once.
   always_comb begin
      hdr_take = valid && (((state_q == IDLE) && !wait_low_q) || (state_q == HEADER));
      hdr_idx  = (state_q == HEADER) ? hdr_cnt_q : 5'd0;
      ld_src   = hdr_take && (hdr_idx <= 5'd3);
      ld_dst   = hdr_take && (hdr_idx >= 5'd4) && (hdr_idx <= 5'd7);
      ld_len   = hdr_take && (hdr_idx >= 5'd8) && (hdr_idx <= 5'd11);
   end

   nibble_shift16 u_src (.clk(clk), .rst(rst), .load_en(ld_src), .din(din), .q(src_port));
   nibble_shift16 u_dst (.clk(clk), .rst(rst), .load_en(ld_dst), .din(din), .q(dst_port));
   nibble_shift16 u_len (.clk(clk), .rst(rst), .load_en(ld_len), .din(din), .q(udp_len));

   always_comb begin
      state_d      = state_q;
      hdr_cnt_d    = hdr_cnt_q;
      rem_d        = rem_q;
      wait_low_d   = wait_low_q & valid;
      dout_ready_d = 1'b0;
      dout_d       = 4'h0;
      frame_done_d = 1'b0;
      err_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (hdr_take) begin
               state_d   = HEADER;
               hdr_cnt_d = 5'd1;
            end
         end
         HEADER: begin
            if (!valid) begin
               err_d     = 1'b1;
               state_d   = IDLE;
               hdr_cnt_d = 5'd0;
            end else if (hdr_cnt_q == HDR_LAST) begin
               // dst_port and udp_len are already settled; checksum is dropped.
               hdr_cnt_d = 5'd0;
               if (udp_len < HDR_LEN) begin
                  err_d   = 1'b1;
                  state_d = FLUSH;
               end else if (dst_port != LISTEN_PORT) begin
                  state_d = DROP;
               end else if (udp_len == HDR_LEN) begin
                  frame_done_d = 1'b1;
                  state_d      = FLUSH;
               end else begin
                  state_d = PAYLOAD;
                  rem_d   = {udp_len - HDR_LEN, 1'b0};
               end
            end else begin
               hdr_cnt_d = hdr_cnt_q + 5'd1;
            end
         end
         PAYLOAD: begin
            if (!valid) begin
               err_d   = 1'b1;
               state_d = IDLE;
               rem_d   = '0;
            end else begin
               dout_ready_d = 1'b1;
               dout_d       = din;
               rem_d        = rem_q - 17'd1;
               if (rem_q == 17'd1) begin
                  frame_done_d = 1'b1;
                  state_d      = FLUSH;
               end
            end
         end
         DROP, FLUSH: begin
            if (!valid) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hdr_cnt_q    <= '0;
         rem_q        <= '0;
         wait_low_q   <= 1'b1;
         dout_ready_q <= 1'b0;
         dout_q       <= 4'h0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_cnt_q    <= hdr_cnt_d;
         rem_q        <= rem_d;
         wait_low_q   <= wait_low_d;
         dout_ready_q <= dout_ready_d;
         dout_q       <= dout_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign dout_ready = dout_ready_q;
   assign dout       = dout_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_udp_decode.sv
// Randomized and directed checks of udp_decode against a frame-level model.
module tb_udp_decode;

   localparam logic [15:0] LISTEN = 16'd8080;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [3:0]  din = 4'h0;
   logic        dout_ready;
   logic [3:0]  dout;
   logic [15:0] src_port;
   logic [15:0] dst_port;
   logic        frame_done;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [3:0] frm[$];

   udp_decode #(.LISTEN_PORT(LISTEN)) dut (
      .clk(clk), .rst(rst), .valid(valid), .din(din),
      .dout_ready(dout_ready), .dout(dout),
      .src_port(src_port), .dst_port(dst_port),
      .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push16(input logic [15:0] v);
      for (int i = 3; i >= 0; i--) frm.push_back(v[i*4 +: 4]);
   endtask

   task automatic push8(input logic [7:0] v);
      frm.push_back(v[7:4]);
      frm.push_back(v[3:0]);
   endtask

   task automatic build(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                        input int pay, input int pad, input bit deadbeef);
      logic [31:0] w;
      w = 32'hDEADBEEF;
      frm.delete();
      push16(src);
      push16(dst);
      push16(len);
      push16(16'($urandom));
      for (int i = 0; i < pay; i++) begin
         if (deadbeef && i < 4) push8(w[31 - 8*i -: 8]);
         else                   push8(8'($urandom));
      end
      for (int i = 0; i < pad; i++) push8(8'($urandom));
   endtask

   // Sends the first n_send nibbles of frm, then gap idle cycles. rst_at >= 0
   // asserts reset together with that nibble. obs index k holds outputs
   // after the edge that sampled input cycle k.
   task automatic run_frame(input int n_send, input int gap, input int rst_at);
      int total;
      int rem;
      logic [15:0] len, dst, src;
      bit       e_rdy[];
      bit       e_done[];
      bit       e_err[];
      bit [3:0] e_dout[];
      total  = n_send + gap;
      e_rdy  = new[total];
      e_done = new[total];
      e_err  = new[total];
      e_dout = new[total];
      src = {frm[0], frm[1], frm[2], frm[3]};
      dst = {frm[4], frm[5], frm[6], frm[7]};
      len = {frm[8], frm[9], frm[10], frm[11]};
      if (n_send < 16) begin
         e_err[n_send] = 1'b1;
      end else if (len < 16'd8) begin
         e_err[15] = 1'b1;
      end else if (dst != LISTEN) begin
         // dropped silently
      end else if (len == 16'd8) begin
         e_done[15] = 1'b1;
      end else begin
         rem = (int'(len) - 8) * 2;
         for (int k = 16; k < 16 + rem && k < n_send; k++) begin
            e_rdy[k]  = 1'b1;
            e_dout[k] = frm[k];
         end
         if (n_send >= 16 + rem) e_done[16 + rem - 1] = 1'b1;
         else                    e_err[n_send] = 1'b1;
      end
      if (rst_at >= 0) begin
         for (int k = rst_at; k < total; k++) begin
            e_rdy[k] = 1'b0; e_done[k] = 1'b0; e_err[k] = 1'b0; e_dout[k] = 4'h0;
         end
      end
      for (int k = 0; k < total; k++) begin
         @(negedge clk);
         valid = (k < n_send);
         din   = (k < n_send) ? frm[k] : 4'h0;
         rst   = (k == rst_at);
         @(posedge clk);
         #1;
         cyc++;
         chk("dout_ready", 32'(dout_ready), 32'(e_rdy[k]));
         chk("dout", 32'(dout), 32'(e_dout[k]));
         chk("frame_done", 32'(frame_done), 32'(e_done[k]));
         chk("err", 32'(err), 32'(e_err[k]));
         if (k == rst_at) begin
            chk("rst_src", 32'(src_port), 32'h0);
            chk("rst_dst", 32'(dst_port), 32'h0);
         end
      end
      if (rst_at < 0 && n_send >= 8) begin
         chk("src_port", 32'(src_port), 32'(src));
         chk("dst_port", 32'(dst_port), 32'(dst));
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] r_dst, r_len;
      int pay, full, n_send;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 32'(dout_ready), 32'h0);
      chk("reset_dout", 32'(dout), 32'h0);
      chk("reset_done", 32'(frame_done), 32'h0);
      chk("reset_err", 32'(err), 32'h0);
      chk("reset_src", 32'(src_port), 32'h0);
      chk("reset_dst", 32'(dst_port), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // matching frame, DE AD BE EF
      build(16'h1F90, 16'h1F90, 16'h000C, 4, 0, 1'b1);
      run_frame(frm.size(), 2, -1);
      // port mismatch
      build(16'h1234, 16'h0035, 16'h0010, 8, 0, 1'b0);
      run_frame(frm.size(), 1, -1);
      // bad length
      build(16'h4321, LISTEN, 16'h0004, 0, 0, 1'b0);
      run_frame(frm.size(), 1, -1);
      // header-only datagram
      build(16'h0001, LISTEN, 16'h0008, 0, 0, 1'b0);
      run_frame(frm.size(), 1, -1);
      // one payload byte plus IP padding
      build(16'h0BAD, LISTEN, 16'h0009, 1, 3, 1'b0);
      run_frame(frm.size(), 1, -1);
      // truncation after 4 payload nibbles
      build(16'h1F90, 16'h1F90, 16'h000C, 4, 0, 1'b1);
      run_frame(20, 1, -1);
      // reset at payload nibble 2, then a clean frame after a 1-cycle gap
      build(16'h1F90, 16'h1F90, 16'h000C, 4, 0, 1'b1);
      run_frame(frm.size(), 1, 18);
      build(16'h1F90, 16'h1F90, 16'h000C, 4, 0, 1'b1);
      run_frame(frm.size(), 2, -1);

      for (int f = 0; f < 60; f++) begin
         r_dst = ($urandom_range(0, 2) != 0) ? LISTEN : 16'($urandom);
         r_len = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 7))
                                            : 16'($urandom_range(8, 24));
         pay   = (r_len >= 16'd8) ? int'(r_len) - 8 : 0;
         build(16'($urandom), r_dst, r_len, pay, int'($urandom_range(0, 3)), 1'b0);
         full   = frm.size();
         n_send = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, full)) : full;
         run_frame(n_send, int'($urandom_range(1, 3)), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
